// File: rtl/accum_zone_bank_if.sv
// Command/data channels of accum_zone_bank: a write channel (command + data halves)
// and a read channel with fixed-latency, non-back-pressured return data.
interface accum_zone_bank_if #(
  parameter int NUM_BANKS  = 4,
  parameter int NUM_ZONES  = 4,
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 64
) ();
  localparam int ZONE_WIDTH = $clog2(NUM_ZONES);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                            wr_valid;
  logic                            wr_ready;
  logic [ZONE_WIDTH-1:0]           wr_zone_id;
  logic                            accum_en;
  logic [NUM_BANKS-1:0]            wr_mask;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic                            wvalid;
  logic                            wready;
  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata;
  logic                            rd_valid;
  logic                            rd_ready;
  logic [ZONE_WIDTH-1:0]           rd_zone_id;
  logic [NUM_BANKS-1:0]            rd_mask;
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic                            rvalid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata;

  modport master (
    output wr_valid, wr_zone_id, accum_en, wr_mask, wr_addr, wvalid, wdata,
    output rd_valid, rd_zone_id, rd_mask, rd_addr,
    input  wr_ready, wready, rd_ready, rvalid, rdata
  );

  modport slave (
    input  wr_valid, wr_zone_id, accum_en, wr_mask, wr_addr, wvalid, wdata,
    input  rd_valid, rd_zone_id, rd_mask, rd_addr,
    output wr_ready, wready, rd_ready, rvalid, rdata
  );
endinterface

// File: rtl/accum_zone_bank.sv
// Multi-bank, multi-zone accumulator memory: two-stage read-modify-write write path with
// one-deep forwarding, and a two-cycle read path; per-lane wrapping or saturating adds.
module accum_zone_bank #(
  parameter int NUM_BANKS  = 4,
  parameter int NUM_ZONES  = 4,
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 64,
  parameter int LANES      = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  accum_zone_bank_if.slave bus
);
  localparam int ZONE_WIDTH = $clog2(NUM_ZONES);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int LANE_WIDTH = DATA_WIDTH / LANES;
  localparam int WORDS      = NUM_ZONES * DEPTH;
  localparam int IDX_WIDTH  = $clog2(WORDS);
  localparam int BUS_WIDTH  = NUM_BANKS * DATA_WIDTH;

  typedef logic [IDX_WIDTH-1:0]  idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic word_t lane_add(input word_t a, input word_t b);
    word_t                 r;
    logic [LANE_WIDTH-1:0] x, y, s;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      x = a[l*LANE_WIDTH +: LANE_WIDTH];
      y = b[l*LANE_WIDTH +: LANE_WIDTH];
      s = x + y;
      // Signed overflow only when both operands share a sign the sum does not.
      if (SATURATE && (x[LANE_WIDTH-1] == y[LANE_WIDTH-1]) && (s[LANE_WIDTH-1] != x[LANE_WIDTH-1]))
        s = x[LANE_WIDTH-1] ? {1'b1, {(LANE_WIDTH-1){1'b0}}} : {1'b0, {(LANE_WIDTH-1){1'b1}}};
      r[l*LANE_WIDTH +: LANE_WIDTH] = s;
    end
    return r;
  endfunction

  function automatic logic zone_ok(input logic [ZONE_WIDTH-1:0] zone);
    return 32'(zone) < NUM_ZONES;
  endfunction

  function automatic idx_t phys_idx(input logic [ZONE_WIDTH-1:0] zone,
                                    input logic [ADDR_WIDTH-1:0] addr);
    return zone_ok(zone) ? idx_t'(zone) * idx_t'(DEPTH) + idx_t'(addr) : '0;
  endfunction

  logic                 ready_q;
  logic                 wr_fire, rd_fire, wr_zone_ok, rd_zone_ok;
  idx_t                 wr_idx, rd_idx;

  logic                 s1_valid_q, s1_zone_ok_q, s1_accum_q;
  logic [NUM_BANKS-1:0] s1_mask_q;
  idx_t                 s1_idx_q;
  logic [BUS_WIDTH-1:0] s1_wdata_q;
  logic [NUM_BANKS-1:0] commit_en, fwd_hit_d, fwd_hit_q;

  logic                 rd_s1_valid_q, rvalid_q;
  logic [NUM_BANKS-1:0] rd_mask_q;
  logic [BUS_WIDTH-1:0] rd_masked, rdata_q;

  assign wr_fire    = bus.wr_valid && bus.wvalid && ready_q;
  assign rd_fire    = bus.rd_valid && ready_q;
  assign wr_zone_ok = zone_ok(bus.wr_zone_id);
  assign rd_zone_ok = zone_ok(bus.rd_zone_id);
  assign wr_idx     = phys_idx(bus.wr_zone_id, bus.wr_addr);
  assign rd_idx     = phys_idx(bus.rd_zone_id, bus.rd_addr);

  assign bus.wr_ready = ready_q;
  assign bus.wready   = ready_q;
  assign bus.rd_ready = ready_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q       <= 1'b0;
      s1_valid_q    <= 1'b0;
      fwd_hit_q     <= '0;
      rd_s1_valid_q <= 1'b0;
      rd_mask_q     <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      ready_q       <= 1'b1;
      s1_valid_q    <= wr_fire;
      fwd_hit_q     <= fwd_hit_d;
      rd_s1_valid_q <= rd_fire;
      if (rd_fire) rd_mask_q <= rd_zone_ok ? bus.rd_mask : '0;
      rvalid_q      <= rd_s1_valid_q;
      rdata_q       <= rd_s1_valid_q ? rd_masked : '0;
    end
  end

  // NOTE: payload registers and the arrays carry no reset; every use is qualified by a
  // reset-cleared valid bit, and leaving them out keeps the arrays mappable to RAM macros.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      s1_zone_ok_q <= wr_zone_ok;
      s1_accum_q   <= bus.accum_en;
      s1_mask_q    <= bus.wr_mask;
      s1_idx_q     <= wr_idx;
      s1_wdata_q   <= bus.wdata;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    word_t mem [WORDS];
    word_t rmw_q, rd_raw_q, fwd_data_q;
    word_t old_word, new_word, s1_word;

    assign s1_word  = s1_wdata_q[b*DATA_WIDTH +: DATA_WIDTH];
    // The array read issued at accept misses a commit landing on that same edge.
    assign old_word = fwd_hit_q[b] ? fwd_data_q : rmw_q;
    assign new_word = s1_accum_q ? lane_add(old_word, s1_word) : s1_word;

    assign commit_en[b] = s1_valid_q && s1_zone_ok_q && s1_mask_q[b];
    assign fwd_hit_d[b] = wr_fire && wr_zone_ok && bus.wr_mask[b] && commit_en[b] &&
                          (s1_idx_q == wr_idx);
    assign rd_masked[b*DATA_WIDTH +: DATA_WIDTH] = rd_mask_q[b] ? rd_raw_q : '0;

    always_ff @(posedge clk) begin
      if (commit_en[b]) mem[s1_idx_q] <= new_word;
      if (wr_fire) begin
        rmw_q      <= mem[wr_idx];
        fwd_data_q <= new_word;
      end
      if (rd_fire) rd_raw_q <= mem[rd_idx];
    end
  end
endmodule

// File: tb/tb_accum_zone_bank.sv
// Bench for accum_zone_bank: a wrapping and a saturating instance share one stimulus
// stream and are compared every cycle against an in-order memory model.
module tb_accum_zone_bank;
  localparam int NB = 4;
  localparam int NZ = 3;
  localparam int DEP = 512;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  accum_zone_bank_if #(.NUM_BANKS(NB), .NUM_ZONES(NZ), .DEPTH(DEP), .DATA_WIDTH(DW)) if_w ();
  accum_zone_bank_if #(.NUM_BANKS(NB), .NUM_ZONES(NZ), .DEPTH(DEP), .DATA_WIDTH(DW)) if_s ();

  assign if_s.wr_valid   = if_w.wr_valid;
  assign if_s.wr_zone_id = if_w.wr_zone_id;
  assign if_s.accum_en   = if_w.accum_en;
  assign if_s.wr_mask    = if_w.wr_mask;
  assign if_s.wr_addr    = if_w.wr_addr;
  assign if_s.wvalid     = if_w.wvalid;
  assign if_s.wdata      = if_w.wdata;
  assign if_s.rd_valid   = if_w.rd_valid;
  assign if_s.rd_zone_id = if_w.rd_zone_id;
  assign if_s.rd_mask    = if_w.rd_mask;
  assign if_s.rd_addr    = if_w.rd_addr;

  accum_zone_bank #(.NUM_BANKS(NB), .NUM_ZONES(NZ), .DEPTH(DEP), .DATA_WIDTH(DW),
                    .LANES(4), .SATURATE(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(if_w));
  accum_zone_bank #(.NUM_BANKS(NB), .NUM_ZONES(NZ), .DEPTH(DEP), .DATA_WIDTH(DW),
                    .LANES(4), .SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));

  typedef struct {
    logic [1:0]   zone;
    bit           accum;
    logic [3:0]   mask;
    logic [2:0]   addr;
    logic [255:0] wdata;
  } wr_cmd_t;

  typedef struct {
    logic [15:0] old_v;
    logic [15:0] add_v;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
    string       name;
  } sat_vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: plain per-entry words, writes applied in commit order.
  logic [63:0]  mw [NZ][8][NB];
  logic [63:0]  ms [NZ][8][NB];
  bit           ready_m = 1'b0;
  bit           pend_v = 1'b0;
  wr_cmd_t      pend;
  bit           mid_v = 1'b0, out_v = 1'b0;
  logic [255:0] mid_w, mid_s, out_w = '0, out_s = '0;
  logic [255:0] obs_w [$];
  logic [255:0] obs_s [$];
  sat_vec_t     vecs [6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] add_word(input logic [63:0] a, input logic [63:0] b, input bit sat);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      int x, y, s;
      x = int'($signed(a[l*16 +: 16]));
      y = int'($signed(b[l*16 +: 16]));
      s = x + y;
      if (sat && s > 32767)  s = 32767;
      if (sat && s < -32768) s = -32768;
      r[l*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [63:0] word4(input logic [15:0] v);
    return {4{v}};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_edge();
    bit aw, ar;
    aw = if_w.wr_valid && if_w.wvalid && ready_m;
    ar = if_w.rd_valid && ready_m;
    out_v = mid_v;
    out_w = mid_w;
    out_s = mid_s;
    mid_v = ar;
    if (ar) begin
      mid_w = '0;
      mid_s = '0;
      for (int b = 0; b < NB; b++)
        if (if_w.rd_mask[b] && int'(if_w.rd_zone_id) < NZ) begin
          mid_w[b*64 +: 64] = mw[if_w.rd_zone_id][if_w.rd_addr[2:0]][b];
          mid_s[b*64 +: 64] = ms[if_w.rd_zone_id][if_w.rd_addr[2:0]][b];
        end
    end
    if (pend_v && int'(pend.zone) < NZ)
      for (int b = 0; b < NB; b++)
        if (pend.mask[b]) begin
          mw[pend.zone][pend.addr][b] = pend.accum ?
            add_word(mw[pend.zone][pend.addr][b], pend.wdata[b*64 +: 64], 1'b0) : pend.wdata[b*64 +: 64];
          ms[pend.zone][pend.addr][b] = pend.accum ?
            add_word(ms[pend.zone][pend.addr][b], pend.wdata[b*64 +: 64], 1'b1) : pend.wdata[b*64 +: 64];
        end
    pend_v = aw;
    if (aw) begin
      pend.zone  = if_w.wr_zone_id;
      pend.accum = if_w.accum_en;
      pend.mask  = if_w.wr_mask;
      pend.addr  = if_w.wr_addr[2:0];
      pend.wdata = if_w.wdata;
    end
    ready_m = 1'b1;
  endtask

  task automatic check_outputs();
    check("hs_w", {if_w.wr_ready, if_w.wready, if_w.rd_ready, if_w.rvalid}, {ready_m, ready_m, ready_m, out_v});
    check("hs_s", {if_s.wr_ready, if_s.wready, if_s.rd_ready, if_s.rvalid}, {ready_m, ready_m, ready_m, out_v});
    check("rdata_w", if_w.rdata, out_v ? out_w : '0);
    check("rdata_s", if_s.rdata, out_v ? out_s : '0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_outputs();
    if (if_w.rvalid) obs_w.push_back(if_w.rdata);
    if (if_s.rvalid) obs_s.push_back(if_s.rdata);
  endtask

  task automatic idle();
    if_w.wr_valid = 1'b0;
    if_w.wvalid   = 1'b0;
    if_w.rd_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] zone, input bit accum, input logic [3:0] mask,
                    input logic [2:0] addr, input logic [255:0] data);
    if_w.wr_valid   = 1'b1;
    if_w.wvalid     = 1'b1;
    if_w.wr_zone_id = zone;
    if_w.accum_en   = accum;
    if_w.wr_mask    = mask;
    if_w.wr_addr    = {6'd0, addr};
    if_w.wdata      = data;
    tick();
    if_w.wr_valid = 1'b0;
    if_w.wvalid   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] zone, input logic [3:0] mask, input logic [2:0] addr);
    if_w.rd_valid   = 1'b1;
    if_w.rd_zone_id = zone;
    if_w.rd_mask    = mask;
    if_w.rd_addr    = {6'd0, addr};
    tick();
    if_w.rd_valid = 1'b0;
  endtask

  task automatic expect_read(input string name, input logic [255:0] ew, input logic [255:0] es);
    logic [255:0] aw, as;
    aw = 'x;
    as = 'x;
    if (obs_w.size() > 0) aw = obs_w.pop_front();
    if (obs_s.size() > 0) as = obs_s.pop_front();
    check({name, "_w"}, aw, ew);
    check({name, "_s"}, as, es);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    ready_m = 1'b0;
    pend_v  = 1'b0;
    mid_v   = 1'b0;
    out_v   = 1'b0;
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h7FF0, 16'h0020, 16'h8010, 16'h7FFF, "pos_ovf"};
    vecs[1] = '{16'h8005, 16'hFFF0, 16'h7FF5, 16'h8000, "neg_ovf"};
    vecs[2] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000, "to_zero"};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'hFFFE, 16'h7FFF, "max_max"};
    vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 16'h8000, "min_min"};
    vecs[5] = '{16'h1234, 16'h0001, 16'h1235, 16'h1235, "plain"};

    for (int z = 0; z < NZ; z++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < NB; b++) begin
          mw[z][a][b] = '0;
          ms[z][a][b] = '0;
        end
    if_w.wr_zone_id = '0; if_w.accum_en = 1'b0; if_w.wr_mask = '0; if_w.wr_addr = '0;
    if_w.wdata = '0; if_w.rd_zone_id = '0; if_w.rd_mask = '0; if_w.rd_addr = '0;
    idle();

    // Reset state, then readies rise on the first edge after release.
    do_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_release", {if_w.wr_ready, if_s.rd_ready}, 2'b11);

    for (int z = 0; z < NZ; z++)
      for (int a = 0; a < 8; a++) wr(2'(z), 1'b0, 4'hF, 3'(a), rand256());
    drain(2);

    // Overwrite then read two cycles later; rvalid exactly two cycles after accept.
    wr(2'd2, 1'b0, 4'hF, 3'd5, fill(16'h0001));
    drain(1);
    obs_w.delete(); obs_s.delete();
    rd(2'd2, 4'hF, 3'd5);
    check("lat_not_early", 32'(obs_w.size()), 32'd0);
    idle();
    tick();
    check("lat_two", 32'(obs_w.size()), 32'd1);
    expect_read("ovw_readback", fill(16'h0001), fill(16'h0001));

    // Eight back-to-back accumulates into banks 0 and 2.
    wr(2'd1, 1'b0, 4'hF, 3'd0, {word4(16'hABCD), word4(16'h0000), word4(16'hABCD), word4(16'h0000)});
    for (int i = 0; i < 8; i++) wr(2'd1, 1'b1, 4'b0101, 3'd0, fill(16'h0003));
    drain(1);
    obs_w.delete(); obs_s.delete();
    rd(2'd1, 4'hF, 3'd0);
    drain(3);
    expect_read("b2b_accum", {word4(16'hABCD), word4(16'h0018), word4(16'hABCD), word4(16'h0018)},
                             {word4(16'hABCD), word4(16'h0018), word4(16'hABCD), word4(16'h0018)});

    // Wrap vs saturate table; overwrite and accumulate issued back to back.
    for (int i = 0; i < 6; i++) begin
      wr(2'd0, 1'b0, 4'hF, 3'd1, fill(vecs[i].old_v));
      wr(2'd0, 1'b1, 4'hF, 3'd1, fill(vecs[i].add_v));
      drain(1);
      obs_w.delete(); obs_s.delete();
      rd(2'd0, 4'hF, 3'd1);
      drain(3);
      expect_read(vecs[i].name, fill(vecs[i].exp_wrap), fill(vecs[i].exp_sat));
    end

    // Read accepted on the commit edge sees the old value; one cycle later the new.
    wr(2'd0, 1'b0, 4'hF, 3'd2, fill(16'h0100));
    drain(2);
    obs_w.delete(); obs_s.delete();
    wr(2'd0, 1'b1, 4'hF, 3'd2, fill(16'h0001));
    rd(2'd0, 4'hF, 3'd2);
    rd(2'd0, 4'hF, 3'd2);
    drain(3);
    check("rdc_pulses", 32'(obs_w.size()), 32'd2);
    expect_read("rdc_old", fill(16'h0100), fill(16'h0100));
    expect_read("rdc_new", fill(16'h0101), fill(16'h0101));

    // Half-handshakes, invalid zone and partial-mask reads.
    wr(2'd1, 1'b0, 4'hF, 3'd3, fill(16'h2222));
    wr(2'd0, 1'b0, 4'hF, 3'd3, {word4(16'h4444), word4(16'h3333), word4(16'h2222), word4(16'h1111)});
    drain(2);
    if_w.wvalid = 1'b1; if_w.wr_valid = 1'b0; if_w.wr_zone_id = 2'd1; if_w.accum_en = 1'b0;
    if_w.wr_mask = 4'hF; if_w.wr_addr = 9'd3; if_w.wdata = fill(16'h5555);
    tick();
    if_w.wvalid = 1'b0; if_w.wr_valid = 1'b1;
    tick();
    idle();
    wr(2'd3, 1'b0, 4'hF, 3'd3, fill(16'h7777));
    drain(2);
    obs_w.delete(); obs_s.delete();
    rd(2'd1, 4'hF, 3'd3);
    rd(2'd3, 4'hF, 3'd3);
    rd(2'd0, 4'b0110, 3'd3);
    drain(3);
    check("hs_zone_pulses", 32'(obs_w.size()), 32'd3);
    expect_read("half_handshake", fill(16'h2222), fill(16'h2222));
    expect_read("bad_zone_read", '0, '0);
    expect_read("partial_mask", {64'd0, word4(16'h3333), word4(16'h2222), 64'd0},
                                {64'd0, word4(16'h3333), word4(16'h2222), 64'd0});

    // Randomized traffic with heavy address reuse.
    for (int i = 0; i < 400; i++) begin
      if_w.wr_valid   = 1'($urandom_range(0, 1));
      if_w.wvalid     = 1'($urandom_range(0, 3) != 0);
      if_w.wr_zone_id = 2'($urandom_range(0, 3));
      if_w.accum_en   = 1'($urandom_range(0, 1));
      if_w.wr_mask    = 4'($urandom_range(0, 15));
      if_w.wr_addr    = 9'($urandom_range(0, 3));
      if_w.wdata      = rand256();
      if_w.rd_valid   = 1'($urandom_range(0, 1));
      if_w.rd_zone_id = 2'($urandom_range(0, 3));
      if_w.rd_mask    = 4'($urandom_range(0, 15));
      if_w.rd_addr    = 9'($urandom_range(0, 3));
      tick();
    end
    drain(3);

    // Reset mid-traffic: in-flight accumulate and read are dropped.
    wr(2'd2, 1'b0, 4'hF, 3'd6, fill(16'h0A0A));
    drain(2);
    obs_w.delete(); obs_s.delete();
    if_w.rd_valid = 1'b1; if_w.rd_zone_id = 2'd2; if_w.rd_mask = 4'hF; if_w.rd_addr = 9'd6;
    wr(2'd2, 1'b1, 4'hF, 3'd6, fill(16'h0001));
    idle();
    do_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_midreset", {if_w.wr_ready, if_w.wready, if_w.rd_ready}, 3'b111);
    drain(2);
    check("no_rvalid_after_reset", 32'(obs_w.size() + obs_s.size()), 32'd0);
    rd(2'd2, 4'hF, 3'd6);
    drain(3);
    expect_read("dropped_write", fill(16'h0A0A), fill(16'h0A0A));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
